clock_enable_gen: RTL and testbench
===================================

Name: clock_enable_gen

Overview:
- Multi-channel clock-enable generator and PLL-lock reset sequencer.
- Runs in the single PLL output clock domain (e.g. 108 MHz from the 24 MHz board clock).
- Produces per-channel single-cycle enable strobes at runtime-programmable integer divisors, so downstream logic (pixel, UART, timer) shares one global clock instead of extra PLL outputs.
- Holds a downstream reset asserted until PLL lock has been stable for a programmable time.

Parameters:
- CHANNELS, 4, number of enable outputs (1..16).
- DIV_WIDTH, 16, divisor width in bits.
- LOCK_CYCLES, 1024, consecutive synchronised lock cycles required before release (>=1).
- DIV_RESET, 1, divisor loaded into every channel at reset (0 = channel off).

Ports:
- clk  in  1  PLL output clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- pll_locked  in  1  PLL lock flag; asynchronous to clk.
- cfg_valid  in  1  divisor-write request.
- cfg_ready  out  1  write accepted when cfg_valid & cfg_ready.
- cfg_channel  in  clog2(CHANNELS) (min 1)  target channel.
- cfg_divisor  in  DIV_WIDTH  new divisor; 0 disables the channel.
- ce_out  out  CHANNELS  per-channel one-cycle enable strobes.
- rst_n_out  out  1  downstream active-low reset.
- ready  out  1  high while in RUN.

Behaviour:
- Reset (reset=0 at an edge) outputs and state:
  - ce_out=0, rst_n_out=0, ready=0, cfg_ready=0.
  - All divisors=DIV_RESET; pending flags cleared; state=WAIT_LOCK.
  - Reset mid-operation aborts everything within that cycle.
- Lock path:
  - pll_locked passes through a 2-flop synchroniser giving lock_s.
  - No other logic samples pll_locked directly.
- State machine (states WAIT_LOCK, STABILISE, RUN):
  - WAIT_LOCK: stab counter=0. lock_s=1 -> STABILISE.
  - STABILISE: counter increments each cycle.
    - lock_s=0 -> back to WAIT_LOCK; counter restarts from 0.
    - counter==LOCK_CYCLES-1 with lock_s=1 -> RUN.
  - RUN: lock_s=0 -> WAIT_LOCK.
    - Same edge: rst_n_out=0, ready=0, ce_out=0, all channel counters reloaded.
  - rst_n_out and ready are registered, high exactly for cycles spent in RUN.
  - Release timing: with pll_locked held high from edge t, rst_n_out first reads 1 after edge t+LOCK_CYCLES+2.
- Channel counters (one DIV_WIDTH counter per channel):
  - On RUN entry, each counter loads divisor-1.
  - In RUN, counter==0 -> ce_out[n]=1 for that cycle and reload divisor-1; otherwise decrement, ce_out[n]=0.
  - Result: first strobe in the DIV-th RUN cycle, then period DIV exactly.
  - Divisor 1 -> ce_out[n] high every RUN cycle.
  - Divisor 0 -> ce_out[n] stuck 0, counter idle.
  - Outside RUN, ce_out=0.
- Configuration:
  - cfg_ready=1 whenever reset=1 and no update is pending for cfg_channel (combinational on cfg_channel).
  - Accepted write stores the value in pend_div[n] and sets pend[n].
  - Pending value is applied glitch-free:
    - Live enabled channel: at the channel's next reload (counter==0), which reloads with new divisor-1.
    - Channel currently at divisor 0, or state != RUN: on the next edge, with counter=new divisor-1.
  - pend[n] clears when applied.
  - Write accepted on the same edge as a reload of that channel: old divisor governs that reload; new value applies at the following reload.
  - cfg_channel >= CHANNELS: cfg_ready=1, write discarded.
- Width rules:
  - No arithmetic beyond decrement and divisor-1.
  - divisor-1 is computed only for nonzero divisors (no wrap).

Test Plan:
- Lock release: reset low 3 cycles, then high; pll_locked=1 from cycle 10; LOCK_CYCLES=8 -> rst_n_out and ready rise at cycle 20, ce_out all 0 before that.
- Lock glitch: pll_locked drops 1 cycle midway through STABILISE -> counter restarts; release delayed by the full LOCK_CYCLES after re-lock; no ce_out pulse.
- Divisors:
  - DIV_RESET=1, then write ch1=3, ch2=0 before lock.
  - In RUN: ch0 strobes every cycle; ch1 strobes at RUN cycles 3, 6, 9; ch2 never strobes.
- Live change:
  - ch1 running at 5; write 2 at RUN cycle 2.
  - Required: strobe at cycle 5 (old period), then 7, 9.
  - cfg_ready low for ch1 between cycles 2 and 5; a second write to ch1 is held off until then.
- Lock loss in RUN -> same cycle as lock_s falls: rst_n_out=0, ready=0, ce_out=0. After re-lock and LOCK_CYCLES, strobes restart with phase from RUN entry.
- Reset mid-RUN -> next edge all outputs at reset values and divisors back to DIV_RESET, discarding the written values.

Source files
------------

// File: rtl/clock_enable_gen.sv
// clock_enable_gen
//   Multi-channel clock-enable generator with a PLL-lock reset sequencer.
//   Everything runs on the single PLL output clock. Each channel emits a
//   one-cycle enable strobe every DIV cycles while the sequencer is in RUN.
//   The downstream reset stays asserted until the synchronised lock flag has
//   been high for LOCK_CYCLES consecutive cycles.
//
// Ports
//   clk          PLL output clock, rising edge
//   reset        synchronous active-low reset
//   pll_locked   PLL lock flag, asynchronous to clk
//   cfg_valid    divisor write request
//   cfg_ready    write accepted when cfg_valid & cfg_ready
//   cfg_channel  target channel of the write
//   cfg_divisor  new divisor, 0 turns the channel off
//   ce_out       per-channel enable strobes
//   rst_n_out    downstream active-low reset
//   ready        high while in RUN
module clock_enable_gen #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned DIV_RESET   = 1,
  localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pll_locked,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_channel,
  input  logic [DIV_WIDTH-1:0] cfg_divisor,
  output logic [CHANNELS-1:0]  ce_out,
  output logic                 rst_n_out,
  output logic                 ready
);

  localparam int unsigned ST_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [DIV_WIDTH-1:0] DIV_INIT  = DIV_WIDTH'(DIV_RESET);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [ST_W-1:0]      STAB_LAST = ST_W'(LOCK_CYCLES - 1);
  localparam logic [ST_W-1:0]      STAB_ONE  = ST_W'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILISE,
    RUN
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [ST_W-1:0] stab_cnt;
  logic [ST_W-1:0] stab_cnt_next;
  logic [1:0]      sync_q;
  logic            lock_s;
  logic            run;

  logic [DIV_WIDTH-1:0] div_q      [CHANNELS];
  logic [DIV_WIDTH-1:0] cnt_q      [CHANNELS];
  logic [DIV_WIDTH-1:0] pend_div_q [CHANNELS];
  logic [CHANNELS-1:0]  pend_q;
  logic [CHANNELS-1:0]  ch_hit;
  logic [CHANNELS-1:0]  wr_en;

  // Reload value for a divisor; a zero divisor parks the counter at 0
  // instead of wrapping.
  function automatic logic [DIV_WIDTH-1:0] reload_of(input logic [DIV_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - DIV_ONE;
  endfunction

  // Two-flop synchroniser; lock_s is the only consumer of pll_locked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign lock_s = sync_q[1];

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= WAIT_LOCK;
      stab_cnt <= '0;
    end else begin
      state    <= state_next;
      stab_cnt <= stab_cnt_next;
    end
  end

  // Sequencer next state; the stabilise counter is zero outside STABILISE.
  always_comb begin
    state_next    = state;
    stab_cnt_next = '0;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) state_next = STABILISE;
      end
      STABILISE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
        end else if (stab_cnt == STAB_LAST) begin
          state_next = RUN;
        end else begin
          stab_cnt_next = stab_cnt + STAB_ONE;
        end
      end
      RUN: begin
        if (!lock_s) state_next = WAIT_LOCK;
      end
      default: state_next = WAIT_LOCK;
    endcase
  end

  // Sequencer outputs, decoded straight from the state flops
  always_comb begin
    run       = (state == RUN);
    ready     = run;
    rst_n_out = run;
  end

  // Write decode; an out-of-range channel matches nothing, so it is always
  // ready and silently dropped.
  always_comb begin
    ch_hit = '0;
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      ch_hit[n] = (cfg_channel == CH_W'(n));
    end
  end

  assign cfg_ready = reset && ((pend_q & ch_hit) == '0);
  assign wr_en     = (cfg_valid && cfg_ready) ? ch_hit : '0;

  // Channel counters. A counter reloads whenever it is outside RUN, off, or
  // at zero; only at a reload may a pending divisor take effect, so a live
  // channel never sees a truncated or stretched period. A write landing on
  // a reload edge only sets pend, so the old divisor governs that reload.
  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      if (!reset) begin
        div_q[n]      <= DIV_INIT;
        cnt_q[n]      <= reload_of(DIV_INIT);
        pend_div_q[n] <= '0;
        pend_q[n]     <= 1'b0;
      end else begin
        if (wr_en[n]) begin
          pend_div_q[n] <= cfg_divisor;
          pend_q[n]     <= 1'b1;
        end
        if (!run || (div_q[n] == '0) || (cnt_q[n] == '0)) begin
          if (pend_q[n]) begin
            div_q[n]  <= pend_div_q[n];
            cnt_q[n]  <= reload_of(pend_div_q[n]);
            pend_q[n] <= 1'b0;
          end else begin
            cnt_q[n] <= reload_of(div_q[n]);
          end
        end else begin
          cnt_q[n] <= cnt_q[n] - DIV_ONE;
        end
      end
    end
  end

  always_comb begin
    ce_out = '0;
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      ce_out[n] = run && (div_q[n] != '0) && (cnt_q[n] == '0);
    end
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// tb_clock_enable_gen
//   Directed bench for clock_enable_gen with 3 channels, 16-bit divisors and
//   an 8-cycle lock window. Each task drives one scenario and checks it
//   against hand-computed values.
module tb_clock_enable_gen;

  localparam int CH   = 3;
  localparam int DW   = 16;
  localparam int LOCK = 8;

  logic          clk;
  logic          reset;
  logic          pll_locked;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_channel;
  logic [DW-1:0] cfg_divisor;
  logic [CH-1:0] ce_out;
  logic          rst_n_out;
  logic          ready;

  int vectors     = 0;
  int miscompares = 0;

  clock_enable_gen #(
    .CHANNELS   (CH),
    .DIV_WIDTH  (DW),
    .LOCK_CYCLES(LOCK),
    .DIV_RESET  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_channel(cfg_channel),
    .cfg_divisor(cfg_divisor),
    .ce_out     (ce_out),
    .rst_n_out  (rst_n_out),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    pll_locked  = 1'b0;
    cfg_valid   = 1'b0;
    cfg_channel = 2'd0;
    cfg_divisor = '0;
    repeat (3) step();
    vectors++;
    if (ce_out !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ce_out: got %b expected 000", ce_out);
    end
    vectors++;
    if (rst_n_out !== 1'b0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rst_ready: got rst_n_out=%b ready=%b expected 0 0", rst_n_out, ready);
    end
    vectors++;
    if (cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cfg_ready: got %b expected 0", cfg_ready);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_cfg_ready: got %b expected 1", cfg_ready);
    end
  endtask

  // ch1=3, ch2=0 and an out-of-range write, all before lock
  task automatic test_cfg_prelock();
    cfg_channel = 2'd1;
    cfg_divisor = 16'd3;
    cfg_valid   = 1'b1;
    #1;
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_ch1_ready: got %b expected 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    #1;
    vectors++;
    if (cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_ch1_pending: got %b expected 0", cfg_ready);
    end
    step();
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_ch1_applied: got %b expected 1", cfg_ready);
    end
    cfg_channel = 2'd2;
    cfg_divisor = 16'd0;
    cfg_valid   = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    cfg_channel = 2'd3;
    cfg_divisor = 16'd0;
    cfg_valid   = 1'b1;
    #1;
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_out_of_range_ready: got %b expected 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  // pll_locked sampled high from edge t; release after edge t+LOCK+2
  task automatic test_lock_release();
    int bad = 0;
    pll_locked = 1'b1;
    for (int k = 1; k <= LOCK + 2; k++) begin
      step();
      if (ready !== 1'b0 || rst_n_out !== 1'b0 || ce_out !== 3'b000) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL release_hold: got %0d early-active cycles expected 0", bad);
    end
    step();
    vectors++;
    if (ready !== 1'b1 || rst_n_out !== 1'b1) begin
      miscompares++;
      $display("FAIL release_edge: got rst_n_out=%b ready=%b expected 1 1", rst_n_out, ready);
    end
  endtask

  // RUN cycles 1..9: ch0 every cycle, ch1 at 3,6,9, ch2 never
  task automatic test_divisors();
    logic [CH-1:0] exp;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) step();
      exp = {1'b0, (k % 3 == 0), 1'b1};
      vectors++;
      if (ce_out !== exp) begin
        miscompares++;
        $display("FAIL divisors_cycle%0d: got %b expected %b", k, ce_out, exp);
      end
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    repeat (3) step();
    vectors++;
    if (ready !== 1'b0 || rst_n_out !== 1'b0 || ce_out !== 3'b000) begin
      miscompares++;
      $display("FAIL lock_loss: got rst_n_out=%b ready=%b ce_out=%b expected 0 0 000",
               rst_n_out, ready, ce_out);
    end
    // outside RUN a write applies on the following edge
    cfg_channel = 2'd1;
    cfg_divisor = 16'd5;
    cfg_valid   = 1'b1;
    step();
    cfg_valid = 1'b0;
    #1;
    vectors++;
    if (cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_write_pending: got %b expected 0", cfg_ready);
    end
    step();
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_write_applied: got %b expected 1", cfg_ready);
    end
  endtask

  // lock drops for the single edge g, 5 edges after relock began;
  // release then follows as if lock started at g+1 (after edge g+LOCK+3)
  task automatic test_lock_glitch();
    int bad = 0;
    pll_locked = 1'b1;
    repeat (5) begin
      step();
      if (ready !== 1'b0 || ce_out !== 3'b000) bad++;
    end
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    if (ready !== 1'b0 || ce_out !== 3'b000) bad++;
    for (int j = 1; j <= LOCK + 2; j++) begin
      step();
      if (ready !== 1'b0 || rst_n_out !== 1'b0 || ce_out !== 3'b000) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL glitch_hold: got %0d early-active cycles expected 0", bad);
    end
    step();
    vectors++;
    if (ready !== 1'b1 || rst_n_out !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_release: got rst_n_out=%b ready=%b expected 1 1", rst_n_out, ready);
    end
  endtask

  // ch1 at 5, write 2 in RUN cycle 2, a held-off write in 3..5, and a write
  // of 3 landing on the reload edge of cycle 7: ch1 strobes 5,7,9,12
  task automatic test_live_change();
    logic [CH-1:0] exp;
    logic          exp_rdy;
    logic          ch1;
    for (int k = 1; k <= 13; k++) begin
      cfg_channel = 2'd1;
      cfg_valid   = (k >= 2 && k <= 5) || (k == 7);
      cfg_divisor = (k == 2) ? 16'd2 : 16'd3;
      #1;
      if (k >= 2 && k <= 10) begin
        exp_rdy = !((k >= 3 && k <= 5) || k == 8 || k == 9);
        vectors++;
        if (cfg_ready !== exp_rdy) begin
          miscompares++;
          $display("FAIL live_cfg_ready_cycle%0d: got %b expected %b", k, cfg_ready, exp_rdy);
        end
      end
      ch1 = (k == 5) || (k == 7) || (k == 9) || (k == 12);
      exp = {1'b0, ch1, 1'b1};
      vectors++;
      if (ce_out !== exp) begin
        miscompares++;
        $display("FAIL live_ce_cycle%0d: got %b expected %b", k, ce_out, exp);
      end
      step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int bad = 0;
    reset = 1'b0;
    #1;
    vectors++;
    if (cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_cfg_ready: got %b expected 0", cfg_ready);
    end
    step();
    vectors++;
    if (ready !== 1'b0 || rst_n_out !== 1'b0 || ce_out !== 3'b000) begin
      miscompares++;
      $display("FAIL midrun_reset: got rst_n_out=%b ready=%b ce_out=%b expected 0 0 000",
               rst_n_out, ready, ce_out);
    end
    reset = 1'b1;
    for (int k = 1; k <= LOCK + 2; k++) begin
      step();
      if (ready !== 1'b0 || ce_out !== 3'b000) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midrun_relock_hold: got %0d early-active cycles expected 0", bad);
    end
    step();
    vectors++;
    if (ready !== 1'b1 || ce_out !== 3'b111) begin
      miscompares++;
      $display("FAIL midrun_defaults: got ready=%b ce_out=%b expected 1 111", ready, ce_out);
    end
    step();
    vectors++;
    if (ce_out !== 3'b111) begin
      miscompares++;
      $display("FAIL midrun_defaults_2: got %b expected 111", ce_out);
    end
  endtask

  initial begin
    test_reset();
    test_cfg_prelock();
    test_lock_release();
    test_divisors();
    test_lock_loss();
    test_lock_glitch();
    test_live_change();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
